// File: rtl/rob_complete_tracker.sv
// ROB completion tracker: keeps per-entry finished/exception state, grants
// allocations against free space, and reports how many entries at the head
// are ready to retire.
//
// Allocation handshake: alloc_req_num acts as the request (0 means no request)
// and alloc_ack is a combinational grant in the same cycle. Rename may only
// consider the ids starting at alloc_rob_id_base as allocated in a cycle where
// alloc_ack is high. The grant is taken at the next clock edge unless flush is
// asserted in that cycle.
module rob_complete_tracker #(
  parameter int ROB_SIZE     = 32,
  parameter int ROB_ID_WIDTH = 5,
  parameter int WB_WIDTH     = 6,
  parameter int COMMIT_WIDTH = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WB_WIDTH-1:0]              wb_enable,
  input  logic [WB_WIDTH-1:0]              wb_valid,
  input  logic [WB_WIDTH*ROB_ID_WIDTH-1:0] wb_rob_id,
  input  logic [WB_WIDTH-1:0]              wb_has_exception,
  input  logic [CNT_WIDTH-1:0]             alloc_req_num,
  output logic                             alloc_ack,
  output logic [ROB_ID_WIDTH-1:0]          alloc_rob_id_base,
  input  logic [CNT_WIDTH-1:0]             retire_num,
  input  logic                             flush,
  output logic [CNT_WIDTH-1:0]             ready_count,
  output logic                             head_exception,
  output logic                             rob_full,
  output logic                             rob_empty,
  output logic                             err_sticky
);

  localparam int PW = ROB_ID_WIDTH + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]           head, tail, head_n, tail_n;
  logic [PW-1:0]           occupancy, free_cnt;
  logic [ROB_SIZE-1:0]     finish, exc, finish_n, exc_n;
  logic                    err_n;
  logic [ROB_ID_WIDTH-1:0] head_idx, tail_idx;
  logic [ROB_ID_WIDTH-1:0] scan_idx, nx_idx, wb_id, wb_off;
  logic                    scan_stop;
  logic [CNT_WIDTH-1:0]    ret_eff;

  assign head_idx          = head[ROB_ID_WIDTH-1:0];
  assign tail_idx          = tail[ROB_ID_WIDTH-1:0];
  assign occupancy         = tail - head;
  assign free_cnt          = PW'(ROB_SIZE) - occupancy;
  assign rob_full          = (occupancy == PW'(ROB_SIZE));
  assign rob_empty         = (head == tail);
  assign alloc_ack         = (free_cnt >= PW'(alloc_req_num));
  assign alloc_rob_id_base = tail_idx;
  assign head_exception    = ~rob_empty & finish[head_idx] & exc[head_idx];

  // Count finished entries from head; an excepting entry is counted and ends the run.
  always_comb begin
    ready_count = '0;
    scan_stop   = 1'b0;
    scan_idx    = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      scan_idx = head_idx + ROB_ID_WIDTH'(i);
      if (!scan_stop && (PW'(i) < occupancy) && finish[scan_idx]) begin
        ready_count = ready_count + CNT_WIDTH'(1);
        if (exc[scan_idx]) scan_stop = 1'b1;
      end else begin
        scan_stop = 1'b1;
      end
    end
  end

  // Next-state: allocation clears new entries, writeback marks completion,
  // retirement frees head entries; flush discards all of it.
  always_comb begin
    head_n   = head;
    tail_n   = tail;
    finish_n = finish;
    exc_n    = exc;
    err_n    = err_sticky;
    nx_idx   = '0;
    wb_id    = '0;
    wb_off   = '0;
    ret_eff  = retire_num;

    // New entries lie outside the old window, so clearing them never collides
    // with a writeback or a retirement in the same cycle.
    if (alloc_ack && (alloc_req_num != '0)) begin
      tail_n = tail + PW'(alloc_req_num);
      for (int i = 0; i < (1 << CNT_WIDTH); i++) begin
        if (i < int'(alloc_req_num)) begin
          nx_idx           = tail_idx + ROB_ID_WIDTH'(i);
          finish_n[nx_idx] = 1'b0;
          exc_n[nx_idx]    = 1'b0;
        end
      end
    end

    // Ascending channel order lets the highest channel win on duplicate ids.
    for (int i = 0; i < WB_WIDTH; i++) begin
      if (wb_enable[i] && wb_valid[i]) begin
        wb_id  = wb_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
        wb_off = wb_id - head_idx;
        if ({1'b0, wb_off} < occupancy) begin
          finish_n[wb_id] = 1'b1;
          exc_n[wb_id]    = wb_has_exception[i];
        end else begin
          err_n = 1'b1;
        end
        for (int j = 0; j < i; j++) begin
          if (wb_enable[j] && wb_valid[j] &&
              (wb_rob_id[j*ROB_ID_WIDTH +: ROB_ID_WIDTH] == wb_id))
            err_n = 1'b1;
        end
      end
    end

    // Over-asking commit is clamped to what is actually ready.
    if (retire_num > ready_count) begin
      ret_eff = ready_count;
      err_n   = 1'b1;
    end
    head_n = head + PW'(ret_eff);
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (i < int'(ret_eff)) begin
        nx_idx           = head_idx + ROB_ID_WIDTH'(i);
        finish_n[nx_idx] = 1'b0;
        exc_n[nx_idx]    = 1'b0;
      end
    end

    // The error latch survives a flush; only reset clears it.
    if (flush) begin
      head_n   = '0;
      tail_n   = '0;
      finish_n = '0;
      exc_n    = '0;
      err_n    = err_sticky;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      finish     <= '0;
      exc        <= '0;
      err_sticky <= 1'b0;
    end else begin
      head       <= head_n;
      tail       <= tail_n;
      finish     <= finish_n;
      exc        <= exc_n;
      err_sticky <= err_n;
    end
  end

endmodule

// File: tb/tb_rob_complete_tracker.sv
// Directed bench for rob_complete_tracker: the driver pushes hand-computed
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_rob_complete_tracker;

  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  wb_enable = '0;
  logic [5:0]  wb_valid = '0;
  logic [29:0] wb_rob_id = '0;
  logic [5:0]  wb_has_exception = '0;
  logic [2:0]  alloc_req_num = '0;
  logic        alloc_ack;
  logic [4:0]  alloc_rob_id_base;
  logic [2:0]  retire_num = '0;
  logic        flush = 1'b0;
  logic [2:0]  ready_count;
  logic        head_exception, rob_full, rob_empty, err_sticky;

  logic [2*W-1:0] exp_q[$];
  string          name_q[$];
  int             tests = 0;
  int             fails = 0;

  rob_complete_tracker dut (
    .clk(clk), .rst(rst),
    .wb_enable(wb_enable), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
    .wb_has_exception(wb_has_exception),
    .alloc_req_num(alloc_req_num), .alloc_ack(alloc_ack),
    .alloc_rob_id_base(alloc_rob_id_base),
    .retire_num(retire_num), .flush(flush),
    .ready_count(ready_count), .head_exception(head_exception),
    .rob_full(rob_full), .rob_empty(rob_empty), .err_sticky(err_sticky)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  // push expected outputs for the current cycle; -1 means don't care
  task automatic ex(input string nm, input int ack, input int base, input int rc,
                    input int hexc, input int full, input int empty, input int err);
    logic [W-1:0] v, m;
    v = '0; m = '0;
    if (ack   >= 0) begin v[12]   = ack[0];   m[12]   = 1'b1; end
    if (base  >= 0) begin v[11:7] = base[4:0]; m[11:7] = '1;  end
    if (rc    >= 0) begin v[6:4]  = rc[2:0];  m[6:4]  = '1;   end
    if (hexc  >= 0) begin v[3]    = hexc[0];  m[3]    = 1'b1; end
    if (full  >= 0) begin v[2]    = full[0];  m[2]    = 1'b1; end
    if (empty >= 0) begin v[1]    = empty[0]; m[1]    = 1'b1; end
    if (err   >= 0) begin v[0]    = err[0];   m[0]    = 1'b1; end
    exp_q.push_back({m, v});
    name_q.push_back(nm);
  endtask

  task automatic wb(input int ch, input int id, input bit e);
    wb_enable[ch] = 1'b1;
    wb_valid[ch]  = 1'b1;
    wb_rob_id[ch*5 +: 5] = id[4:0];
    wb_has_exception[ch] = e;
  endtask

  // advance one cycle, then return all inputs to idle
  task automatic tick();
    @(posedge clk);
    #1;
    wb_enable = '0; wb_valid = '0; wb_rob_id = '0; wb_has_exception = '0;
    alloc_req_num = '0; retire_num = '0; flush = 1'b0;
  endtask

  // asynchronous reset pulse away from the clock edge
  task automatic do_reset(input string nm);
    #2 rst = 1'b0;
    ex(nm, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] obs, m, v;
    logic [2*W-1:0] e;
    string nm;
    obs = {alloc_ack, alloc_rob_id_base, ready_count, head_exception,
           rob_full, rob_empty, err_sticky};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      m = e[2*W-1:W];
      v = e[W-1:0];
      tests++;
      if ((obs & m) !== (v & m)) begin
        fails++;
        $display("FAIL %s: got ack=%b base=%0d rc=%0d hexc=%b full=%b empty=%b err=%b (raw %b), required %b under mask %b",
                 nm, obs[12], obs[11:7], obs[6:4], obs[3], obs[2], obs[1], obs[0], obs, v, m);
      end
    end
  end

  initial begin
    // reset
    ex("reset", 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // basic alloc / writeback / retire
    alloc_req_num = 4; ex("t1_alloc", 1, 0, 0, 0, 0, 1, 0); tick();
    wb(0, 1, 0); wb(2, 0, 0); ex("t1_wb", 1, 4, 0, 0, 0, 0, 0); tick();
    retire_num = 2; ex("t1_rc2", -1, 4, 2, 0, 0, 0, 0); tick();
    ex("t1_retired", -1, 4, 0, 0, 0, 0, 0); flush = 1; tick();

    // fill and full behaviour
    for (int k = 0; k < 8; k++) begin
      alloc_req_num = 4; ex("t2_fill", 1, 4*k, -1, -1, 0, -1, 0); tick();
    end
    alloc_req_num = 1; ex("t2_full_nack", 0, 0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 4; i++) wb(i, i, 0);
    ex("t2_tail_hold", -1, 0, 0, -1, 1, 0, 0); tick();
    retire_num = 4; alloc_req_num = 4;
    ex("t2_same_cycle", 0, 0, 4, 0, 1, 0, 0); tick();
    alloc_req_num = 4; ex("t2_reuse", 1, 0, 0, 0, 0, 0, 0); tick();
    ex("t2_refull", -1, 4, -1, -1, 1, 0, 0); flush = 1; tick();

    // exception stops the ready scan
    alloc_req_num = 4; ex("t3_alloc", 1, 0, 0, 0, 0, 1, 0); tick();
    wb(0, 0, 0); wb(1, 1, 1); wb(2, 2, 0); wb(3, 3, 0); tick();
    retire_num = 1; ex("t3_rc2", -1, 4, 2, 0, 0, 0, 0); tick();
    ex("t3_hexc", -1, 4, 1, 1, 0, 0, 0); flush = 1; tick();

    // walk pointers to 30, then wrap
    for (int k = 0; k < 8; k++) begin
      int n;
      n = (k < 7) ? 4 : 2;
      alloc_req_num = 3'(n); ex("t4_walk_alloc", 1, 4*k, 0, 0, 0, 1, 0); tick();
      for (int i = 0; i < n; i++) wb(i, 4*k + i, 0);
      tick();
      retire_num = 3'(n); ex("t4_walk_rc", -1, -1, n, 0, 0, 0, 0); tick();
    end
    alloc_req_num = 4; ex("t4_at30", 1, 30, 0, 0, 0, 1, 0); tick();
    wb(0, 30, 0); wb(1, 31, 0); wb(2, 0, 0); wb(3, 1, 0); tick();
    retire_num = 4; ex("t4_rc4", -1, 2, 4, 0, 0, 0, 0); tick();
    ex("t4_wrapped", 1, 2, 0, 0, 0, 1, 0); flush = 1; tick();

    // flush with 10 in flight
    alloc_req_num = 4; ex("t5_a0", 1, 0, 0, 0, 0, 1, 0); tick();
    alloc_req_num = 4; ex("t5_a4", 1, 4, 0, 0, 0, 0, 0); tick();
    alloc_req_num = 2; ex("t5_a8", 1, 8, 0, 0, 0, 0, 0); tick();
    wb(0, 0, 0); wb(1, 1, 0); tick();
    flush = 1; retire_num = 2; alloc_req_num = 4; wb(0, 2, 0);
    ex("t5_pre_flush", 1, 10, 2, 0, 0, 0, 0); tick();
    alloc_req_num = 1; ex("t5_flushed", 1, 0, 0, 0, 0, 1, 0); tick();
    ex("t5_realloc", -1, 1, 0, 0, 0, 0, 0); flush = 1; tick();

    // out-of-window writeback
    alloc_req_num = 3; ex("t6_alloc", 1, 0, 0, 0, 0, 1, 0); tick();
    wb(1, 20, 0); ex("t6_wb_oob", -1, 3, 0, 0, 0, 0, 0); tick();
    ex("t6_err", -1, 3, 0, 0, 0, 0, 1); tick();
    do_reset("t6_reset_mid");

    // over-retire clamp
    alloc_req_num = 3; tick();
    wb(0, 0, 0); tick();
    retire_num = 3; ex("t6_rc1", -1, 3, 1, 0, 0, 0, 0); tick();
    wb(0, 1, 0); ex("t6_clamp_err", -1, 3, 0, 0, 0, 0, 1); tick();
    ex("t6_head_moved", -1, 3, 1, 0, 0, 0, 1); tick();
    do_reset("t6_reset_clears");

    // duplicate ids: highest channel wins exc, error latched
    alloc_req_num = 2; tick();
    wb(0, 0, 1); wb(3, 0, 0); tick();
    ex("t7_dup", -1, 2, 1, 0, 0, 0, 1); tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
